// File: rtl/bsg_wormhole_router_pkg.sv
// Shared types for the wormhole router input/output control blocks.
package bsg_wormhole_router_pkg;

    typedef enum logic {eIdle = 1'b0, eLocked = 1'b1} arb_state_e;

endpackage

// File: rtl/bsg_wormhole_router_output_arbiter_if.sv
// Handshake bundle between input controls / output link and one output arbiter.
interface bsg_wormhole_router_output_arbiter_if #(parameter int inputs_p = 4);

    logic [inputs_p-1:0] reqs_i;
    logic [inputs_p-1:0] release_i;
    logic [inputs_p-1:0] valid_i;
    logic                ready_i;
    logic                valid_o;
    logic [inputs_p-1:0] grants_o;
    logic [inputs_p-1:0] yumi_o;
    logic                busy_o;

    modport master (output reqs_i, release_i, valid_i, ready_i,
                    input  valid_o, grants_o, yumi_o, busy_o);

    modport slave  (input  reqs_i, release_i, valid_i, ready_i,
                    output valid_o, grants_o, yumi_o, busy_o);

endinterface

// File: rtl/bsg_wormhole_rr_pick.sv
// Rotate-priority encoder: first set bit of reqs scanning ptr, ptr+1, ... modulo width_p.
module bsg_wormhole_rr_pick #(
    parameter int width_p     = 4,
    parameter int lg_width_lp = $clog2(width_p)
) (
    input  logic [width_p-1:0]     reqs,
    input  logic [lg_width_lp-1:0] ptr,
    output logic                   v,
    output logic [width_p-1:0]     onehot,
    output logic [lg_width_lp-1:0] index
);

    always_comb begin
        int j;
        j      = 0;
        v      = |reqs;
        onehot = '0;
        index  = '0;
        // Walk from the farthest slot back to ptr so the nearest request is written last.
        for (int k = width_p - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= width_p) j = j - width_p;
            if (reqs[j]) begin
                onehot    = '0;
                onehot[j] = 1'b1;
                index     = lg_width_lp'(j);
            end
        end
    end

endmodule

// File: rtl/bsg_wormhole_router_output_arbiter.sv
// Output-direction scheduler: round-robin header pick, then locked to one input per packet.
// Optional statistics counters under `define BSG_WORMHOLE_ARB_STATS_EN.
module bsg_wormhole_router_output_arbiter
    import bsg_wormhole_router_pkg::*;
#(
    parameter int inputs_p     = 4,
    parameter int lg_inputs_lp = $clog2(inputs_p),
    parameter int stat_width_p = 16
) (
    input  logic clk_i,
    input  logic reset_n_i,
    bsg_wormhole_router_output_arbiter_if.slave io
`ifdef BSG_WORMHOLE_ARB_STATS_EN
    , output logic [stat_width_p-1:0] pkt_count_o
    , output logic [stat_width_p-1:0] stall_count_o
`endif
);

    localparam logic [0:0] IDLE_S   = 1'(eIdle);
    localparam logic [0:0] LOCKED_S = 1'(eLocked);

    if (inputs_p < 2 || stat_width_p < 1) begin : g_bad_cfg
        $error("bsg_wormhole_router_output_arbiter: inputs_p must be >= 2, stat_width_p >= 1");
    end

    logic [0:0]              state_r;
    logic [lg_inputs_lp-1:0] owner_r, ptr_r;

    logic                    pick_v;
    logic [inputs_p-1:0]     pick_oh;
    logic [lg_inputs_lp-1:0] pick_idx;

    bsg_wormhole_rr_pick #(.width_p(inputs_p), .lg_width_lp(lg_inputs_lp)) pick (
        .reqs   (io.reqs_i),
        .ptr    (ptr_r),
        .v      (pick_v),
        .onehot (pick_oh),
        .index  (pick_idx)
    );

    logic [inputs_p-1:0] owner_oh;
    logic                own_rel, own_vld;
    logic                valid;
    logic [inputs_p-1:0] grants, yumi;
    logic                hdr_fire;

    assign own_rel = io.release_i[owner_r];
    assign own_vld = io.valid_i[owner_r];

    always_comb begin
        owner_oh          = '0;
        owner_oh[owner_r] = 1'b1;
    end

    // Outputs are forced low while reset is asserted, regardless of registered state.
    always_comb begin
        valid  = 1'b0;
        grants = '0;
        yumi   = '0;
        if (reset_n_i) begin
            if (state_r == IDLE_S) begin
                valid  = pick_v;
                grants = pick_oh;
                yumi   = pick_oh & {inputs_p{io.ready_i}};
            end else if (!own_rel) begin
                valid  = own_vld;
                grants = owner_oh;
                yumi   = owner_oh & {inputs_p{own_vld & io.ready_i}};
            end
        end
    end

    assign hdr_fire = (state_r == IDLE_S) & pick_v & io.ready_i;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE_S;
            owner_r <= '0;
            ptr_r   <= '0;
        end else if (state_r == IDLE_S) begin
            if (hdr_fire) begin
                state_r <= LOCKED_S;
                owner_r <= pick_idx;
            end
        end else if (own_rel) begin
            // Releasing owner drops to lowest priority for the next round.
            state_r <= IDLE_S;
            ptr_r   <= (owner_r == lg_inputs_lp'(inputs_p - 1)) ? '0 : owner_r + 1'b1;
        end
    end

    assign io.valid_o  = valid;
    assign io.grants_o = grants;
    assign io.yumi_o   = yumi;
    assign io.busy_o   = reset_n_i & (state_r == LOCKED_S);

`ifdef BSG_WORMHOLE_ARB_STATS_EN
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            pkt_count_o   <= '0;
            stall_count_o <= '0;
        end else begin
            if (hdr_fire && pkt_count_o != '1)
                pkt_count_o <= pkt_count_o + 1'b1;
            if (valid && !io.ready_i && stall_count_o != '1)
                stall_count_o <= stall_count_o + 1'b1;
        end
    end
`endif

endmodule
